parallax_layer_ctrl: RTL
========================

# parallax_layer_ctrl

Per-frame scroll scheduler for the parallax VGA renderer. A host writes per-layer scroll speed and enable into shadow registers over a valid/ready port. At each vertical-blank tick from the VGA timing generator, the block commits the shadows and then advances each layer's horizontal offset, one layer per cycle. The wrapped offsets drive the renderer's per-layer pixel fetch for the next visible frame.

## Interface

Parameters:
- LAYERS, 4: number of scroll layers (2..8).
- SPEED_W, 4: width of signed per-frame speed.
- OFFSET_W, 10: offset width; must hold H_WRAP-1.
- H_WRAP, 640: offset modulus, equal to active pixels per line.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse at the first line of vertical front porch (line 480 of 520).
- cfg_valid  in  1  host write request.
- cfg_ready  out  1  write accepted when high with cfg_valid.
- cfg_layer  in  $clog2(LAYERS)  target layer.
- cfg_speed  in  SPEED_W  signed pixels per frame.
- cfg_enable  in  1  layer scroll enable.
- offset  out  LAYERS*OFFSET_W  packed current offsets; layer i at [i*OFFSET_W +: OFFSET_W].
- layer_en  out  LAYERS  committed enables.
- busy  out  1  commit/update sequence in progress.
- overrun  out  1  sticky flag: frame_tick arrived while busy.

## Operation

- FSM states: IDLE, COMMIT, UPDATE.
  - IDLE -> COMMIT on frame_tick.
  - COMMIT -> UPDATE after 1 cycle, with idx=0.
  - UPDATE stays for LAYERS cycles, idx 0..LAYERS-1, then returns to IDLE.
- Host write: cfg_ready = (state == IDLE). A transfer occurs when cfg_valid && cfg_ready; shadow_speed[cfg_layer] and shadow_en[cfg_layer] load at that edge. cfg_layer >= LAYERS: the transfer is accepted and discarded.
- COMMIT: speed[i] <= shadow_speed[i] and layer_en[i] <= shadow_en[i] for all i, at the same edge.
- UPDATE idx=i:
  - If layer_en[i] is set: offset[i] <= wrap(offset[i] + sext(speed[i])).
  - Otherwise offset[i] holds.
- Arithmetic: the sum is computed in OFFSET_W+2 signed bits.
  - If sum >= H_WRAP, subtract H_WRAP.
  - If sum < 0, add H_WRAP.
  - |speed| < H_WRAP is guaranteed by the width choice, so one correction step suffices.
  - Result is always in 0..H_WRAP-1.
- frame_tick while not IDLE is ignored and sets overrun. overrun clears only on reset.
- Write and frame_tick in the same IDLE cycle: the write is accepted, and the following COMMIT includes it.

## Timing

- Reset (async assert, sync-released by the top level): state IDLE, all offsets 0, layer_en 0, speed and shadows 0, busy 0, overrun 0, cfg_ready 1.
- With frame_tick sampled at edge T:
  - busy is high from T+1 through T+1+LAYERS (LAYERS+1 cycles).
  - layer_en is updated at edge T+1.
  - offset[i] is updated at edge T+2+i.
  - cfg_ready is low during the same window as busy.
- Every output is registered; there are no combinational paths from inputs to outputs except cfg_ready, which decodes the state register.
- Reset asserted mid-sequence: all state is cleared immediately, and partially updated offsets return to 0.
- All updates finish within 9 lines of front porch, well before active video (LAYERS+1 << 832*40 cycles).

## Configuration

- PARALLAX_FREEZE_EN defined:
  - Adds input port freeze (1 bit).
  - While freeze is high at an UPDATE cycle, the offset for that idx holds.
  - COMMIT and host writes are unaffected.
- PARALLAX_FREEZE_EN undefined: no freeze port; updates behave as if freeze=0.

## Structure

- parallax_pkg holds:
  - state enum (IDLE, COMMIT, UPDATE);
  - H_WRAP_DEFAULT=640;
  - VGA line constants (832 total, 520 total lines, 480 active lines);
  - default widths.
- Sub-module parallax_wrap_add: purely combinational signed add plus modular correction. Parameters OFFSET_W, SPEED_W, H_WRAP. Instantiated once and muxed by idx.

## Test plan

- Reset release -> offsets all 0, cfg_ready=1, busy=0, overrun=0; no change across 3 frame_ticks with no config written.
- Write layer0 speed=+3 enable=1, then 3 frame_ticks -> offset0 = 3, 6, 9; other layers 0; offset0 changes exactly at T+2.
- Layer1 speed=-2 enable=1 from 0 -> offset1 = 638, then 636; layer2 speed=+7 preset so offset2=636 -> next frame offset2=3.
- cfg_valid held during the busy window -> cfg_ready=0 for exactly LAYERS+1 cycles, and the write lands on the first IDLE cycle; a write coincident with frame_tick is applied in that frame.
- Second frame_tick at T+2 -> overrun=1, the ongoing sequence completes unchanged, and overrun stays 1 until reset; reset asserted at T+3 -> everything 0 immediately.
- With PARALLAX_FREEZE_EN, freeze=1 across a tick with layer0 speed=+5 -> offset0 unchanged and layer_en still committed; freeze=0 on the next tick -> offset0 advances by 5.

Source files
------------

// File: rtl/parallax_pkg.sv
// Shared types and constants for the parallax scroll scheduler.
package parallax_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCommit = 2'd1,
    StUpdate = 2'd2
  } state_e;

  localparam int unsigned H_WRAP_DEFAULT   = 640;
  localparam int unsigned LAYERS_DEFAULT   = 4;
  localparam int unsigned SPEED_W_DEFAULT  = 4;
  localparam int unsigned OFFSET_W_DEFAULT = 10;

  // VGA 640x480@72-style frame geometry seen by the renderer.
  localparam int unsigned VGA_H_TOTAL  = 832;
  localparam int unsigned VGA_V_TOTAL  = 520;
  localparam int unsigned VGA_V_ACTIVE = 480;

endpackage

// File: rtl/parallax_wrap_add.sv
// Combinational signed offset + speed with single-step modular correction into 0..H_WRAP-1.
module parallax_wrap_add #(
  parameter int unsigned OFFSET_W = 10,
  parameter int unsigned SPEED_W  = 4,
  parameter int unsigned H_WRAP   = 640
) (
  input  logic [OFFSET_W-1:0]       offset_i,
  input  logic signed [SPEED_W-1:0] speed_i,
  output logic [OFFSET_W-1:0]       offset_o
);

  localparam int unsigned SUM_W = OFFSET_W + 2;
  localparam logic signed [SUM_W-1:0] Wrap = SUM_W'(H_WRAP);

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] fixed;

  always_comb begin
    sum = $signed({2'b00, offset_i}) +
          $signed({{(SUM_W-SPEED_W){speed_i[SPEED_W-1]}}, speed_i});
    fixed = sum;
    if (sum[SUM_W-1]) begin
      fixed = sum + Wrap;
    end else if (sum >= Wrap) begin
      fixed = sum - Wrap;
    end
    offset_o = fixed[OFFSET_W-1:0];
  end

endmodule

// File: rtl/parallax_layer_ctrl.sv
// Per-frame parallax scroll scheduler: commits host shadows on frame_tick, then steps one layer
// per cycle. Optional freeze input is enabled with PARALLAX_FREEZE_EN.
module parallax_layer_ctrl
  import parallax_pkg::*;
#(
  parameter int unsigned LAYERS   = LAYERS_DEFAULT,
  parameter int unsigned SPEED_W  = SPEED_W_DEFAULT,
  parameter int unsigned OFFSET_W = OFFSET_W_DEFAULT,
  parameter int unsigned H_WRAP   = H_WRAP_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
`ifdef PARALLAX_FREEZE_EN
  input  logic                       freeze,
`endif
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [$clog2(LAYERS)-1:0]  cfg_layer,
  input  logic [SPEED_W-1:0]         cfg_speed,
  input  logic                       cfg_enable,
  output logic [LAYERS*OFFSET_W-1:0] offset,
  output logic [LAYERS-1:0]          layer_en,
  output logic                       busy,
  output logic                       overrun
);

  localparam int unsigned LAYER_W = $clog2(LAYERS);

  state_e               state_q, state_d;
  logic [LAYER_W-1:0]   idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  logic signed [SPEED_W-1:0] shadow_speed_q [LAYERS];
  logic signed [SPEED_W-1:0] shadow_speed_d [LAYERS];
  logic signed [SPEED_W-1:0] speed_q [LAYERS];
  logic signed [SPEED_W-1:0] speed_d [LAYERS];
  logic [OFFSET_W-1:0]       offset_q [LAYERS];
  logic [OFFSET_W-1:0]       offset_d [LAYERS];
  logic [LAYERS-1:0]         shadow_en_q, shadow_en_d;
  logic [LAYERS-1:0]         en_q, en_d;

  logic                      freeze_w;
  logic                      cfg_fire;
  logic [OFFSET_W-1:0]       cur_offset;
  logic signed [SPEED_W-1:0] cur_speed;
  logic [OFFSET_W-1:0]       next_offset;

`ifdef PARALLAX_FREEZE_EN
  assign freeze_w = freeze;
`else
  assign freeze_w = 1'b0;
`endif

  assign cfg_ready = (state_q == StIdle);
  assign cfg_fire  = cfg_valid && cfg_ready;

  // Single shared adder, steered to the layer being updated this cycle.
  assign cur_offset = offset_q[idx_q];
  assign cur_speed  = speed_q[idx_q];

  parallax_wrap_add #(
    .OFFSET_W (OFFSET_W),
    .SPEED_W  (SPEED_W),
    .H_WRAP   (H_WRAP)
  ) u_wrap_add (
    .offset_i (cur_offset),
    .speed_i  (cur_speed),
    .offset_o (next_offset)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    if (frame_tick && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        state_d = StUpdate;
        idx_d   = '0;
      end
      StUpdate: begin
        if (idx_q == LAYER_W'(LAYERS - 1)) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_comb begin
    shadow_speed_d = shadow_speed_q;
    shadow_en_d    = shadow_en_q;
    speed_d        = speed_q;
    en_d           = en_q;
    offset_d       = offset_q;
    // Out-of-range cfg_layer matches no entry, so the write is dropped.
    if (cfg_fire) begin
      for (int unsigned i = 0; i < LAYERS; i++) begin
        if (cfg_layer == LAYER_W'(i)) begin
          shadow_speed_d[i] = $signed(cfg_speed);
          shadow_en_d[i]    = cfg_enable;
        end
      end
    end
    if (state_q == StCommit) begin
      speed_d = shadow_speed_q;
      en_d    = shadow_en_q;
    end
    if ((state_q == StUpdate) && en_q[idx_q] && !freeze_w) begin
      offset_d[idx_q] = next_offset;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      shadow_en_q <= '0;
      en_q        <= '0;
      for (int unsigned i = 0; i < LAYERS; i++) begin
        shadow_speed_q[i] <= '0;
        speed_q[i]        <= '0;
        offset_q[i]       <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      shadow_en_q    <= shadow_en_d;
      en_q           <= en_d;
      shadow_speed_q <= shadow_speed_d;
      speed_q        <= speed_d;
      offset_q       <= offset_d;
    end
  end

  for (genvar g = 0; g < LAYERS; g++) begin : g_offset_pack
    assign offset[g*OFFSET_W +: OFFSET_W] = offset_q[g];
  end

  assign layer_en = en_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule
